// File: rtl/aer_pkg.sv
// Shared helpers for the AER spike encoder.
//   addr_w  : index width for N items (minimum 1 bit)
//   ptr_w   : FIFO pointer width, one extra wrap bit over the slot index
//   sat_add : saturating add clipped to a given bit width (width <= 63)
// Configuration macro: AER_TIMESTAMP_EN (used by the top and FIFO event layout).
package aer_pkg;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [63:0] lim;
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous FIFO of AER events.
//   clk, rst_n  : clock, synchronous active-low reset (clears pointers and storage)
//   push, wdata : write request and event; ignored while full
//   pop         : advance head; ignored while empty
//   rdata       : head event (stale content when empty)
//   full, empty : derived from registered pointers only, so a pop never frees
//                 space for a push in the same cycle
// Configuration macro: AER_TIMESTAMP_EN only changes event_t chosen by the parent.
module aer_event_fifo
  import aer_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter type event_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  event_t wdata,
  input  logic   pop,
  output event_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = ptr_w(Depth);

  logic [PtrW-1:0] wptr_q, rptr_q;
  event_t          mem_q [Depth];
  logic            do_push, do_pop;

  // Extra MSB distinguishes full from empty when the slot indices match.
  assign full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                 (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);
  assign empty = (wptr_q == rptr_q);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[PtrW-2:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[PtrW-2:0]] <= wdata;
        wptr_q                  <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/aer_spike_encoder.sv
// AER spike encoder: captures per-neuron spikes, serialises them one per cycle
// through a round-robin arbiter into an event FIFO, and streams the events out.
//   clk, rst_n  : clock, synchronous active-low reset
//   spike_in    : one bit per neuron, 1 = spike this cycle
//   aer_valid   : FIFO head holds an event
//   aer_ready   : consumer accepts the head event when aer_valid && aer_ready
//   aer_addr    : neuron index of head event
//   aer_ts      : push-cycle timestamp of head event (0 when timestamps disabled)
//   overflow    : sticky, a spike was merged into an already pending one
//   drop_count  : number of merged (lost) spikes, saturating
// Configuration macro: AER_TIMESTAMP_EN adds the timestamp counter and FIFO ts field.
module aer_spike_encoder
  import aer_pkg::*;
#(
  parameter int unsigned N_NEURONS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned ADDR_W    = addr_w(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spike_in,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic [ADDR_W-1:0]    aer_addr,
  output logic [TS_WIDTH-1:0]  aer_ts,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] drop_count
);

  // Event layout depends on this instance's widths, so it is declared here.
`ifdef AER_TIMESTAMP_EN
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [TS_WIDTH-1:0] ts;
  } aer_event_t;
`else
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
  } aer_event_t;
`endif

  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [N_NEURONS-1:0] grant, collide;
  logic [ADDR_W-1:0]    rr_q, rr_d;
  logic [ADDR_W-1:0]    gnt_idx;
  logic                 gnt_valid, push, pop;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 fifo_full, fifo_empty;
  aer_event_t           wr_ev, head_ev;

  // Round-robin search: first pending neuron at or after rr_q.
  always_comb begin : arbiter
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      idx = (32'(rr_q) + i) % N_NEURONS;
      if (!gnt_valid && pending_q[ADDR_W'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ADDR_W'(idx);
      end
    end
  end

  always_comb begin
    push       = gnt_valid && !fifo_full;
    grant      = push ? (N_NEURONS'(1) << gnt_idx) : '0;
    // A new spike on a still-pending, ungranted line cannot be told apart: it is lost.
    collide    = spike_in & pending_q & ~grant;
    pending_d  = (pending_q & ~grant) | spike_in;
    rr_d       = rr_q;
    if (push) begin
      rr_d = (gnt_idx == ADDR_W'(N_NEURONS - 1)) ? '0 : gnt_idx + ADDR_W'(1);
    end
    overflow_d = overflow_q | (|collide);
    drop_d     = CNT_WIDTH'(sat_add(64'(drop_q), 64'($countones(collide)), CNT_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      rr_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  assign ts_d = ts_q + TS_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign wr_ev.addr = gnt_idx;
  assign wr_ev.ts   = ts_q;
  assign aer_ts     = head_ev.ts;
`else
  assign wr_ev.addr = gnt_idx;
  assign aer_ts     = '0;
`endif

  assign pop = aer_valid && aer_ready;

  aer_event_fifo #(
    .Depth   (FIFO_DEPTH),
    .event_t (aer_event_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_ev),
    .pop   (pop),
    .rdata (head_ev),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign aer_valid  = !fifo_empty;
  assign aer_addr   = head_ev.addr;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed bench for aer_spike_encoder: default instance plus a TS_WIDTH=4
// instance for timestamp wrap. Expected timestamps follow AER_TIMESTAMP_EN.
module tb_aer_spike_encoder;

`ifdef AER_TIMESTAMP_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  spike;
  logic        ready;
  logic        valid;
  logic [2:0]  addr;
  logic [15:0] ts;
  logic        ovf;
  logic [15:0] drop;

  logic [7:0]  spike2;
  logic        ready2;
  logic        valid2;
  logic [2:0]  addr2;
  logic [3:0]  ts2;
  logic        ovf2;
  logic [15:0] drop2;

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  int bad;
  int ts4_tab [5] = '{1, 5, 9, 13, 1};

  aer_spike_encoder u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike),
    .aer_valid  (valid),
    .aer_ready  (ready),
    .aer_addr   (addr),
    .aer_ts     (ts),
    .overflow   (ovf),
    .drop_count (drop)
  );

  aer_spike_encoder #(
    .TS_WIDTH (4)
  ) u_dut_ts4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike2),
    .aer_valid  (valid2),
    .aer_ready  (ready2),
    .aer_addr   (addr2),
    .aer_ts     (ts2),
    .overflow   (ovf2),
    .drop_count (drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_ts(input int unsigned v);
    return TsEn ? 32'(v) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset edge, then release; caller drives the next stimulus immediately.
  task automatic do_reset();
    rst_n  = 1'b0;
    spike  = '0;
    ready  = 1'b0;
    spike2 = '0;
    ready2 = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    spike  = '0;
    ready  = 1'b0;
    spike2 = '0;
    ready2 = 1'b0;
    tick();
    tick();
    check("rst_valid", valid, 0);
    check("rst_addr", addr, 0);
    check("rst_ts", ts, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop", drop, 0);

    // 1: single spike on neuron 2, two-edge latency
    rst_n = 1'b1;
    spike = 8'h04;
    tick();
    spike = '0;
    check("t1_latency", valid, 0);
    tick();
    check("t1_valid", valid, 1);
    check("t1_addr", addr, 2);
    check("t1_ts", ts, exp_ts(1));
    ready = 1'b1;
    tick();
    check("t1_pop", valid, 0);
    ready = 1'b0;

    // 2: all neurons once, streamed out in index order with consecutive ts
    do_reset();
    spike = 8'hFF;
    ready = 1'b1;
    tick();
    spike = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_valid%0d", i), valid, 1);
      check($sformatf("t2_addr%0d", i), addr, i);
      check($sformatf("t2_ts%0d", i), ts, exp_ts(1 + i));
      tick();
    end
    check("t2_empty", valid, 0);
    check("t2_drop", drop, 0);
    ready = 1'b0;

    // 3: two back-to-back full-width spikes, seven merges
    do_reset();
    ready = 1'b1;
    spike = 8'hFF;
    tick();
    tick();
    spike = '0;
    n   = 0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (valid) begin
        if (addr != 3'((n < 8) ? n : 0)) bad++;
        n++;
      end
      tick();
    end
    check("t3_events", n, 9);
    check("t3_order", bad, 0);
    check("t3_drop", drop, 7);
    check("t3_ovf", ovf, 1);
    ready = 1'b0;

    // 4: backpressure fills the FIFO, third burst waits in pending
    do_reset();
    for (int r = 0; r < 3; r++) begin
      spike = 8'hFF;
      tick();
      spike = '0;
      repeat (9) tick();
    end
    check("t4_valid", valid, 1);
    check("t4_addr_a", addr, 0);
    repeat (3) tick();
    check("t4_addr_b", addr, 0);
    check("t4_drop_hold", drop, 0);
    check("t4_ovf_hold", ovf, 0);
    ready = 1'b1;
    n   = 0;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (valid) begin
        if (addr != 3'(n % 8)) bad++;
        n++;
      end
      tick();
    end
    check("t4_events", n, 24);
    check("t4_order", bad, 0);
    check("t4_drop", drop, 0);
    ready = 1'b0;

    // 5: reset while events are queued
    do_reset();
    spike = 8'h1F;
    tick();
    tick();
    spike = '0;
    repeat (6) tick();
    check("t5_pre_valid", valid, 1);
    check("t5_pre_drop", drop, 4);
    check("t5_pre_ovf", ovf, 1);
    rst_n = 1'b0;
    tick();
    check("t5_valid", valid, 0);
    check("t5_drop", drop, 0);
    check("t5_ovf", ovf, 0);
    check("t5_addr", addr, 0);
    rst_n = 1'b1;
    spike = 8'h01;
    tick();
    spike = '0;
    tick();
    check("t5_post_valid", valid, 1);
    check("t5_post_addr", addr, 0);
    check("t5_post_ts", ts, exp_ts(1));

    // 6: 4-bit timestamp wraps, one spike every 20 cycles
    do_reset();
    ready2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      spike2 = 8'h01;
      tick();
      spike2 = '0;
      tick();
      check($sformatf("t6_valid%0d", k), valid2, 1);
      check($sformatf("t6_ts%0d", k), ts2, exp_ts(ts4_tab[k]));
      repeat (18) tick();
    end
    check("t6_addr", addr2, 0);
    check("t6_drop", drop2, 0);
    check("t6_ovf", ovf2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
